// File: rtl/uart_fifo_param.sv
// rtl/uart_fifo_param.sv - parametrised UART: serializer, deserializer, TX/RX FIFOs
//
// Ports:
//   Pclk, rst_n         clock, asynchronous active-low reset
//   tx_data, tx_push    host word into the TX FIFO
//   rx_pop              pop the RX FIFO head (rx_data is first-word-fall-through)
//   err_clr             clear sticky frame_err / parity_err / overrun
//   rx, tx              serial pins, idle high
//   tx_/rx_ full/empty/count   registered FIFO status
//   busy                TX or RX state machine active
//   irq                 RX level at/above RX_THRESH or any sticky error

module uart_fifo_param_sfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          do_push, do_pop;

  // Gating on the registered flags means a push into a full FIFO is dropped
  // even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;
endmodule

module uart_fifo_param #(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int RX_THRESH    = 1
) (
  input  logic                    Pclk,
  input  logic                    rst_n,
  input  logic [DATA_BITS-1:0]    tx_data,
  input  logic                    tx_push,
  input  logic                    rx_pop,
  input  logic                    err_clr,
  input  logic                    rx,
  output logic                    tx,
  output logic [DATA_BITS-1:0]    rx_data,
  output logic                    tx_full,
  output logic                    tx_empty,
  output logic                    rx_full,
  output logic                    rx_empty,
  output logic [$clog2(DEPTH):0]  tx_count,
  output logic [$clog2(DEPTH):0]  rx_count,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    overrun,
  output logic                    irq
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam int BITW = $clog2(DATA_BITS);
  localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BITW-1:0] DATA_LAST = BITW'(DATA_BITS - 1);
  localparam logic            ODD       = (PARITY == 2);
  localparam logic            HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  // ---------------- TX path ----------------
  state_e                 tx_state_q, tx_state_d;
  logic [CNTW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BITW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_q, tx_d;
  logic                   tx_fifo_pop;
  logic [DATA_BITS-1:0]   tx_fifo_rdata;

  uart_fifo_param_sfifo #(.W(DATA_BITS), .DEPTH(DEPTH)) u_tx_fifo (
    .clk_i   (Pclk),
    .rst_ni  (rst_n),
    .push_i  (tx_push),
    .pop_i   (tx_fifo_pop),
    .wdata_i (tx_data),
    .rdata_o (tx_fifo_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // tx_d is the line level for the next cycle, so each state sets up the
  // level of the bit that follows it; tx stays a clean flop output.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_d        = tx_q;
    tx_fifo_pop = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty) begin
          tx_fifo_pop = 1'b1;
          tx_shift_d  = tx_fifo_rdata;
          tx_par_d    = (^tx_fifo_rdata) ^ ODD;
          tx_cnt_d    = '0;
          tx_bit_d    = '0;
          tx_d        = 1'b0;
          tx_state_d  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNTW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            if (HAS_PAR) begin
              tx_d       = tx_par_q;
              tx_state_d = S_PAR;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = S_STOP;
            end
          end else begin
            tx_bit_d   = tx_bit_q + BITW'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNTW'(1);
        end
      end
      S_PAR: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNTW'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNTW'(1);
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

  // ---------------- RX path ----------------
  state_e                 rx_state_q, rx_state_d;
  logic [CNTW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BITW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_par_q, rx_par_d;
  logic                   rx_meta_q, rx_sync_q;
  logic                   rx_fifo_push;
  logic                   frame_set, parity_set, overrun_set;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;

  uart_fifo_param_sfifo #(.W(DATA_BITS), .DEPTH(DEPTH)) u_rx_fifo (
    .clk_i   (Pclk),
    .rst_ni  (rst_n),
    .push_i  (rx_fifo_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_shift_q),
    .rdata_o (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // Synchroniser presets high so reset never looks like a start bit.
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_par_d     = rx_par_q;
    rx_fifo_push = 1'b0;
    frame_set    = 1'b0;
    parity_set   = 1'b0;
    overrun_set  = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_cnt_d   = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        // Half a bit in: still low means a real start bit, and from here
        // every full bit period lands on a bit centre.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) begin
            rx_bit_d   = '0;
            rx_state_d = S_DATA;
          end else begin
            rx_state_d = S_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNTW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            if (HAS_PAR) rx_state_d = S_PAR;
            else         rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BITW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNTW'(1);
        end
      end
      S_PAR: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNTW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          frame_set  = !rx_sync_q;
          parity_set = HAS_PAR && (rx_par_q != ((^rx_shift_q) ^ ODD));
          if (!frame_set && !parity_set) begin
            if (rx_full) overrun_set  = 1'b1;
            else         rx_fifo_push = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNTW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // A set event in the same cycle as err_clr wins.
  always_comb begin
    frame_err_d  = frame_set   | (frame_err_q  & ~err_clr);
    parity_err_d = parity_set  | (parity_err_q & ~err_clr);
    overrun_d    = overrun_set | (overrun_q    & ~err_clr);
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_q     <= rx_par_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (tx_state_q != S_IDLE) || (rx_state_q != S_IDLE);
  assign irq        = (rx_count >= CW'(RX_THRESH)) | frame_err_q | parity_err_q | overrun_q;
endmodule

// File: tb/tb_uart_fifo_param.sv
// tb/tb_uart_fifo_param.sv - scoreboard bench for uart_fifo_param
module tb_uart_fifo_param;
  localparam int DB = 8, DEPTH = 4, CPB = 4, PAR = 1, THR = 2, CW = 3, FRAME = 11;

  logic          Pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_push = 1'b0, rx_pop = 1'b0, err_clr = 1'b0;
  logic          rx_drv = 1'b1, loop = 1'b0;
  logic          rx_w, tx;
  logic [DB-1:0] rx_data;
  logic          tx_full, tx_empty, rx_full, rx_empty, busy;
  logic [CW-1:0] tx_count, rx_count;
  logic          frame_err, parity_err, overrun, irq;

  assign rx_w = loop ? tx : rx_drv;

  uart_fifo_param #(
    .DATA_BITS(DB), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .PARITY(PAR), .RX_THRESH(THR)
  ) dut (
    .Pclk(Pclk), .rst_n(rst_n), .tx_data(tx_data), .tx_push(tx_push), .rx_pop(rx_pop),
    .err_clr(err_clr), .rx(rx_w), .tx(tx), .rx_data(rx_data), .tx_full(tx_full),
    .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty), .tx_count(tx_count),
    .rx_count(rx_count), .busy(busy), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .irq(irq)
  );

  always #5 Pclk = ~Pclk;

  int checks = 0, errors = 0;
  logic [DB-1:0] rx_exp_q[$];
  logic          tx_exp_q[$];
  logic          tx_mon_en = 1'b1;
  int            tx_pos = -1;
  logic          tx_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX scoreboard: every accepted pop is compared with the oldest expected word.
  always @(negedge Pclk) begin
    logic [DB-1:0] e;
    if (rst_n && rx_pop && !rx_empty) begin
      checks++;
      if (rx_exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_data: got %0h expected no word", rx_data);
      end else begin
        e = rx_exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data: got %0h expected %0h", rx_data, e);
        end
      end
    end
  end

  // TX monitor: finds a start edge, then compares the line at each bit centre.
  always @(negedge Pclk) begin
    logic b;
    if (!rst_n || !tx_mon_en) begin
      tx_pos = -1;
    end else begin
      if (tx_pos < 0 && tx_prev && !tx) tx_pos = 0;
      if (tx_pos >= 0) begin
        if (tx_pos % CPB == CPB / 2) begin
          checks++;
          if (tx_exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_bit: got %0b expected no frame", tx);
          end else begin
            b = tx_exp_q.pop_front();
            if (tx !== b) begin
              errors++;
              $display("FAIL tx_bit %0d: got %0b expected %0b", tx_pos / CPB, tx, b);
            end
          end
        end
        tx_pos++;
        if (tx_pos == FRAME * CPB) tx_pos = -1;
      end
    end
    tx_prev = tx;
  end

  task automatic expect_tx_frame(input logic [DB-1:0] w, input logic p);
    tx_exp_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) tx_exp_q.push_back(w[i]);
    tx_exp_q.push_back(p);
    tx_exp_q.push_back(1'b1);
  endtask

  task automatic push_tx(input logic [DB-1:0] w);
    @(posedge Pclk); #1 tx_data = w; tx_push = 1'b1;
    @(posedge Pclk); #1 tx_push = 1'b0;
  endtask

  task automatic pop_rx();
    @(posedge Pclk); #1 rx_pop = 1'b1;
    @(posedge Pclk); #1 rx_pop = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(posedge Pclk); #1 err_clr = 1'b1;
    @(posedge Pclk); #1 err_clr = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    @(posedge Pclk); #1 rx_drv = b;
    repeat (CPB - 1) @(posedge Pclk);
  endtask

  task automatic send_frame(input logic [DB-1:0] w, input logic p, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(w[i]);
    drive_bit(p);
    drive_bit(stop);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  // {parity bit, word}; parity bits are even parity worked out by hand.
  logic [8:0] ovr_vec [5]  = '{9'h1_10, 9'h0_11, 9'h0_12, 9'h1_13, 9'h0_14};
  logic [8:0] wrap_vec [6] = '{9'h1_20, 9'h0_21, 9'h0_22, 9'h1_23, 9'h0_24, 9'h1_25};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int lows;
    // Reset state
    repeat (3) @(posedge Pclk);
    @(negedge Pclk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_empty", tx_empty, 1'b1);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_counts", {tx_count, rx_count}, 6'd0);
    check("rst_flags", {tx_full, rx_full, busy, frame_err, parity_err, overrun, irq}, 7'd0);
    @(posedge Pclk); #1 rst_n = 1'b1;

    // TX waveform: 0xA5, even parity 0, 44-cycle frame
    expect_tx_frame(8'hA5, 1'b0);
    push_tx(8'hA5);
    @(negedge Pclk);
    check("tx_empty_after_push", tx_empty, 1'b0);
    check("tx_idle_before_start", tx, 1'b1);
    @(negedge Pclk);
    check("tx_start_low", tx, 1'b0);
    check("tx_empty_after_pop", tx_empty, 1'b1);
    repeat (43) @(negedge Pclk);
    check("busy_last_stop_cycle", busy, 1'b1);
    @(negedge Pclk);
    check("busy_after_frame", busy, 1'b0);
    check("tx_high_after_frame", tx, 1'b1);

    // Loopback of two words
    loop = 1'b1;
    expect_tx_frame(8'h3C, 1'b0);
    expect_tx_frame(8'hC3, 1'b0);
    rx_exp_q.push_back(8'h3C);
    rx_exp_q.push_back(8'hC3);
    push_tx(8'h3C);
    push_tx(8'hC3);
    k = 0;
    while (rx_count != 3'd2 && k < 400) begin @(negedge Pclk); k++; end
    check("loop_rx_count", rx_count, 3'd2);
    pop_rx();
    pop_rx();
    @(negedge Pclk);
    check("loop_rx_empty", rx_empty, 1'b1);
    check("loop_no_errors", {frame_err, parity_err, overrun}, 3'd0);
    k = 0;
    while (busy && k < 100) begin @(negedge Pclk); k++; end
    check("loop_busy_done", busy, 1'b0);
    loop = 1'b0;

    // Parity error: 0x01 needs parity 1, send 0
    send_frame(8'h01, 1'b0, 1'b1);
    @(negedge Pclk);
    check("par_err_set", parity_err, 1'b1);
    check("par_err_irq", irq, 1'b1);
    check("par_err_discard", rx_empty, 1'b1);
    check("par_err_no_frame", frame_err, 1'b0);
    pulse_err_clr();
    @(negedge Pclk);
    check("par_err_clr", parity_err, 1'b0);
    check("par_err_irq_clr", irq, 1'b0);

    // Frame error: stop bit 0
    send_frame(8'h55, 1'b0, 1'b0);
    @(negedge Pclk);
    check("frame_err_set", frame_err, 1'b1);
    check("frame_err_discard", rx_empty, 1'b1);
    pulse_err_clr();
    @(negedge Pclk);
    check("frame_err_clr", {frame_err, irq}, 2'b00);

    // Overrun: five frames into a 4-deep FIFO
    for (int i = 0; i < 4; i++) rx_exp_q.push_back(ovr_vec[i][7:0]);
    for (int i = 0; i < 5; i++) send_frame(ovr_vec[i][7:0], ovr_vec[i][8], 1'b1);
    @(negedge Pclk);
    check("ovr_rx_full", rx_full, 1'b1);
    check("ovr_rx_count", rx_count, 3'd4);
    check("ovr_flag", overrun, 1'b1);
    for (int i = 0; i < 4; i++) pop_rx();
    @(negedge Pclk);
    check("ovr_drained", rx_empty, 1'b1);
    pulse_err_clr();
    @(negedge Pclk);
    check("ovr_clr", overrun, 1'b0);

    // Wrap-around: pairs of frames then pairs of pops
    for (int i = 0; i < 6; i++) rx_exp_q.push_back(wrap_vec[i][7:0]);
    for (int p = 0; p < 3; p++) begin
      send_frame(wrap_vec[2*p][7:0], wrap_vec[2*p][8], 1'b1);
      send_frame(wrap_vec[2*p+1][7:0], wrap_vec[2*p+1][8], 1'b1);
      @(negedge Pclk);
      check("wrap_rx_count", rx_count, 3'd2);
      pop_rx();
      pop_rx();
    end

    // Glitch then threshold
    @(posedge Pclk); #1 rx_drv = 1'b0;
    @(posedge Pclk); #1 rx_drv = 1'b1;
    repeat (12) @(posedge Pclk);
    @(negedge Pclk);
    check("glitch_no_push", rx_empty, 1'b1);
    check("glitch_busy_idle", busy, 1'b0);
    rx_exp_q.push_back(8'h5A);
    rx_exp_q.push_back(8'h6B);
    send_frame(8'h5A, 1'b0, 1'b1);
    @(negedge Pclk);
    check("thr_one_count", rx_count, 3'd1);
    check("thr_one_irq", irq, 1'b0);
    send_frame(8'h6B, 1'b1, 1'b1);
    @(negedge Pclk);
    check("thr_two_irq", irq, 1'b1);
    pop_rx();
    @(negedge Pclk);
    check("thr_pop_irq", irq, 1'b0);
    pop_rx();

    // Reset in the middle of a TX frame with words queued
    tx_mon_en = 1'b0;
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    repeat (10) @(posedge Pclk);
    #1;
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_tx_count", tx_count, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_tx_count", tx_count, 3'd0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) @(posedge Pclk);
    #1 rst_n = 1'b1;
    tx_mon_en = 1'b1;
    lows = 0;
    repeat (120) begin
      @(negedge Pclk);
      if (!tx) lows++;
    end
    check("post_rst_no_frame", lows, 0);
    check("post_rst_tx_empty", tx_empty, 1'b1);

    check("tx_exp_drained", tx_exp_q.size(), 0);
    check("rx_exp_drained", rx_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_param.md
Name: uart_fifo_param

Overview:
Parametrised successor UART with TX and RX FIFOs, built self-contained: serializer, deserializer and two synchronous FIFOs in one block. It adds configurable data width, FIFO depth, baud divisor and parity. It also adds FIFO level counts, an RX threshold interrupt, and sticky frame, parity and overrun error flags. It sits between a host-side register interface and the external serial pins.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), sent LSB first.
DEPTH, 16, entries per FIFO; must be a power of 2, at least 2.
CLKS_PER_BIT, 434, Pclk cycles per serial bit; must be at least 4.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
RX_THRESH, 1, RX FIFO level (1..DEPTH) at or above which irq asserts.

Ports:
Pclk  input  1  free-running clock, all logic on rising edge
rst_n  input  1  reset; asynchronous, active-low
tx_data  input  DATA_BITS  word to push into the TX FIFO
tx_push  input  1  push tx_data into the TX FIFO
rx_pop  input  1  pop the head of the RX FIFO
err_clr  input  1  clear all sticky error flags
rx  input  1  serial input (asynchronous to Pclk)
tx  output  1  serial output, idle high
rx_data  output  DATA_BITS  head of RX FIFO (first-word-fall-through)
tx_full, tx_empty, rx_full, rx_empty  output  1 each  FIFO status
tx_count, rx_count  output  $clog2(DEPTH)+1  FIFO occupancy
busy  output  1  TX or RX state machine not IDLE
frame_err, parity_err, overrun  output  1 each  sticky error flags
irq  output  1  (rx_count >= RX_THRESH) | frame_err | parity_err | overrun

Behaviour:
- Reset (rst_n low, asynchronous): both FIFOs emptied, counts 0, tx=1, all flags 0, irq=0, busy=0, both FSMs to IDLE, RX synchroniser flops preset to 1. Reset mid-frame aborts the frame immediately.
- FIFOs: circular buffers with pointers one bit wider than the address; wrap-around at DEPTH.
  - A push when full is ignored, even if a pop occurs in the same cycle.
  - A pop when empty is ignored.
  - Simultaneous push and pop when neither full nor empty: count unchanged, both take effect.
  - Status and count outputs are registered and update the cycle after the push or pop.
  - rx_data is valid whenever rx_empty=0.
- Frame format: start bit (0), DATA_BITS data bits LSB first, parity bit if PARITY!=0, one stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
  - Even parity: XOR of the data bits.
  - Odd parity: inverse of that XOR.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE with tx_empty=0: pop the TX FIFO that cycle, latch the word, enter START. tx goes low on the next cycle.
  - PAR is skipped when PARITY=0.
  - At the end of STOP, return to IDLE. Back-to-back frames therefore have exactly one idle-high Pclk cycle between the stop bit and the next start bit.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - rx passes through a 2-flop synchroniser.
  - IDLE: a synchronised low level enters START.
  - START: at CLKS_PER_BIT/2 cycles, if the line is still low, continue; otherwise treat it as a glitch and return to IDLE.
  - Sample each subsequent bit at its centre, every CLKS_PER_BIT cycles.
  - Stop-sample cycle:
    - stop=0: set frame_err.
    - parity mismatch: set parity_err.
    - any error: discard the word.
    - no error and FIFO not full: push the word.
    - no error and FIFO full: discard the word and set overrun.
  - Return to IDLE the cycle after the stop sample.
- Sticky flags:
  - Set on their events and held until err_clr.
  - If err_clr and a set event occur in the same cycle, the set wins.
- tx_push and rx_pop may be asserted on every cycle; each assertion is one operation.

Test Plan:
- TX waveform (DATA_BITS=8, PARITY=1, CLKS_PER_BIT=4): push 0xA5 -> tx is low 4 cycles, then bits 1,0,1,0,0,1,0,1, then parity 0, then stop 1; frame is 44 cycles; tx_empty=1 one cycle after the pop.
- Loopback (tx tied to rx): push 0x3C, 0xC3 -> rx_count reaches 2; rx_data reads 0x3C, then 0xC3 after one rx_pop; no error flags set.
- Parity error: drive a frame of 0x01 with parity bit 0 (even mode) -> parity_err=1, irq=1, rx_empty stays 1; err_clr -> parity_err=0, irq=0.
- Overrun / wrap-around (DEPTH=4): drive 5 frames 0x10..0x14 with no pops -> rx_full=1, rx_count=4, overrun=1; pops return 0x10..0x13. Then drive and pop 6 more frames -> correct order maintained across pointer wrap.
- Threshold and glitch (RX_THRESH=2): a 1-cycle low pulse on rx -> no push, busy returns 0. Then one frame -> irq=0; second frame -> irq=1; one rx_pop -> irq=0.
- Reset mid-frame: assert rst_n=0 during the DATA bits of a TX frame with 3 words queued -> tx=1 and tx_count=0 immediately; no further frames are sent after reset is released.
